ir_int_registers: RTL and testbench

IR_INT_REGISTERS -- requirements
Module: ir_int_registers

---
 rtl/ir_int_registers_pkg.sv | 8 +
 rtl/ir_int_registers_int_ctl.sv | 51 +++++
 rtl/ir_int_registers.sv | 65 ++++++
 tb/tb_ir_int_registers.sv | 103 ++++++++++
 4 files changed

// File: rtl/ir_int_registers_pkg.sv
// ir_int_registers_pkg: shared z80 interrupt-mode encodings and EI delay limit
package ir_int_registers_pkg;
  typedef enum logic [1:0] {IM0 = 2'd0, IM1 = 2'd1, IM2 = 2'd2} im_t;
  localparam int EI_DELAY_MAX = 15;
  function automatic logic [1:0] im_map(input logic [1:0] v);
    return (v == 2'd3) ? IM2 : v;
  endfunction
endpackage

// File: rtl/ir_int_registers_int_ctl.sv
// int_ctl: IFF1/IFF2, interrupt mode and EI-delay counter
module int_ctl
  import ir_int_registers_pkg::*;
#(
  parameter int EI_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_done,
  input  logic       ei,
  input  logic       di,
  input  logic       retn,
  input  logic       int_ack,
  input  logic       nmi_ack,
  input  logic       im_wr,
  input  logic [1:0] im_in,
  output logic       iff1,
  output logic       iff2,
  output logic [1:0] im,
  output logic       ei_pending,
  output logic       int_enable
);
  localparam int CW = $clog2(EI_DELAY + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic iff1_n, iff2_n;
  logic clr;
  // next state: nmi_ack > int_ack/di > ei > retn; the counter freezes on nmi_ack
  always_comb begin
    clr = int_ack | di;
    iff1_n = nmi_ack ? 1'b0 : clr ? 1'b0 : ei ? 1'b1 : retn ? iff2 : iff1;
    iff2_n = nmi_ack ? iff2 : clr ? 1'b0 : ei ? 1'b1 : iff2;
    cnt_n = nmi_ack ? cnt : clr ? '0 : ei ? CW'(EI_DELAY) :
            (instr_done && cnt != '0) ? cnt - 1'b1 : cnt;
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      iff1 <= 1'b0;
      iff2 <= 1'b0;
      cnt  <= '0;
      im   <= IM0;
    end else begin
      iff1 <= iff1_n;
      iff2 <= iff2_n;
      cnt  <= cnt_n;
      im   <= im_wr ? im_map(im_in) : im;
    end
  end
  assign ei_pending = cnt != '0;
  assign int_enable = iff1 & ~ei_pending;
endmodule

// File: rtl/ir_int_registers.sv
// ir_int_registers: Z80 I/R registers with refresh increment plus interrupt control
module ir_int_registers
  import ir_int_registers_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int REFRESH_BITS = 7,
  parameter int EI_DELAY     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wr,
  input  logic [DATA_WIDTH-1:0]   i_in,
  input  logic                    r_wr,
  input  logic [DATA_WIDTH-1:0]   r_in,
  input  logic                    m1_inc,
  input  logic                    instr_done,
  input  logic                    ei,
  input  logic                    di,
  input  logic                    retn,
  input  logic                    int_ack,
  input  logic                    nmi_ack,
  input  logic                    im_wr,
  input  logic [1:0]              im_in,
  output logic [DATA_WIDTH-1:0]   reg_i,
  output logic [DATA_WIDTH-1:0]   reg_r,
  output logic [2*DATA_WIDTH-1:0] refresh_addr,
  output logic                    iff1,
  output logic                    iff2,
  output logic [1:0]              im,
  output logic                    ei_pending,
  output logic                    int_enable
);
  localparam logic [DATA_WIDTH-1:0] R_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - REFRESH_BITS);
  logic [DATA_WIDTH-1:0] r_inc;
  // only the low refresh bits count; the upper bits of R are preserved
  always_comb r_inc = (reg_r & ~R_MASK) | ((reg_r + 1'b1) & R_MASK);
  // I/R registers; an explicit R write wins over the refresh increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_i <= '0;
      reg_r <= '0;
    end else begin
      reg_i <= i_wr ? i_in : reg_i;
      reg_r <= r_wr ? r_in : m1_inc ? r_inc : reg_r;
    end
  end
  assign refresh_addr = {reg_i, reg_r};
  int_ctl #(.EI_DELAY(EI_DELAY)) u_int_ctl (
    .clk        (clk),
    .reset      (reset),
    .instr_done (instr_done),
    .ei         (ei),
    .di         (di),
    .retn       (retn),
    .int_ack    (int_ack),
    .nmi_ack    (nmi_ack),
    .im_wr      (im_wr),
    .im_in      (im_in),
    .iff1       (iff1),
    .iff2       (iff2),
    .im         (im),
    .ei_pending (ei_pending),
    .int_enable (int_enable)
  );
endmodule

// File: tb/tb_ir_int_registers.sv
// tb_ir_int_registers: directed stimulus with a scoreboard queue and negedge monitor
module tb_ir_int_registers;
  logic clk = 1'b0;
  logic reset, i_wr, r_wr, m1_inc, instr_done, ei, di, retn, int_ack, nmi_ack, im_wr;
  logic [7:0] i_in, r_in, reg_i, reg_r;
  logic [1:0] im_in, im;
  logic [15:0] refresh_addr;
  logic iff1, iff2, ei_pending, int_enable;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [7:0] i, r;
    logic f1, f2, p, en;
    logic [1:0] im;
    string tag;
  } exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  ir_int_registers dut (
    .clk(clk), .reset(reset), .i_wr(i_wr), .i_in(i_in), .r_wr(r_wr), .r_in(r_in),
    .m1_inc(m1_inc), .instr_done(instr_done), .ei(ei), .di(di), .retn(retn),
    .int_ack(int_ack), .nmi_ack(nmi_ack), .im_wr(im_wr), .im_in(im_in),
    .reg_i(reg_i), .reg_r(reg_r), .refresh_addr(refresh_addr), .iff1(iff1), .iff2(iff2),
    .im(im), .ei_pending(ei_pending), .int_enable(int_enable)
  );
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (q.size() != 0) begin
      x = q.pop_front();
      chk({x.tag, ".reg_i"}, 16'(reg_i), 16'(x.i));
      chk({x.tag, ".reg_r"}, 16'(reg_r), 16'(x.r));
      chk({x.tag, ".refresh_addr"}, refresh_addr, {x.i, x.r});
      chk({x.tag, ".iff1"}, 16'(iff1), 16'(x.f1));
      chk({x.tag, ".iff2"}, 16'(iff2), 16'(x.f2));
      chk({x.tag, ".im"}, 16'(im), 16'(x.im));
      chk({x.tag, ".ei_pending"}, 16'(ei_pending), 16'(x.p));
      chk({x.tag, ".int_enable"}, 16'(int_enable), 16'(x.en));
    end
  end
  task automatic clr();
    reset = 1'b1; i_wr = 0; r_wr = 0; m1_inc = 0; instr_done = 0; ei = 0; di = 0;
    retn = 0; int_ack = 0; nmi_ack = 0; im_wr = 0; i_in = 8'h00; r_in = 8'h00; im_in = 2'd0;
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    e.tag = tag;
    e.en = e.f1 & ~e.p;
    q.push_back(e);
    clr();
  endtask
  initial begin
    clr();
    e = '{i: 8'h00, r: 8'h00, f1: 0, f2: 0, p: 0, en: 0, im: 2'd0, tag: ""};
    reset = 0; m1_inc = 1; i_wr = 1; i_in = 8'hAA; tick("reset");
    tick("idle");
    r_wr = 1; r_in = 8'hFE; e.r = 8'hFE; tick("r_load_fe");
    m1_inc = 1; e.r = 8'hFF; tick("inc_ff");
    m1_inc = 1; e.r = 8'h80; tick("inc_wrap_80");
    m1_inc = 1; e.r = 8'h81; tick("inc_81");
    r_wr = 1; m1_inc = 1; r_in = 8'h10; e.r = 8'h10; tick("r_wr_over_inc");
    r_wr = 1; r_in = 8'h7F; e.r = 8'h7F; tick("r_load_7f");
    m1_inc = 1; e.r = 8'h00; tick("inc_7f_00");
    i_wr = 1; i_in = 8'h3A; r_wr = 1; r_in = 8'h05; e.i = 8'h3A; e.r = 8'h05; tick("addr_3a05");
    ei = 1; e.f1 = 1; e.f2 = 1; e.p = 1; tick("ei");
    instr_done = 1; e.p = 0; tick("ei_release");
    ei = 1; e.p = 1; tick("ei_again");
    ei = 1; tick("ei_second");
    instr_done = 1; e.p = 0; tick("ei_second_release");
    ei = 1; instr_done = 1; e.p = 1; tick("ei_with_done");
    instr_done = 1; e.p = 0; tick("ei_done_release");
    nmi_ack = 1; e.f1 = 0; tick("nmi");
    retn = 1; e.f1 = 1; tick("retn");
    int_ack = 1; ei = 1; e.f1 = 0; e.f2 = 0; tick("int_ack_over_ei");
    ei = 1; e.f1 = 1; e.f2 = 1; e.p = 1; tick("ei_pre_nmi");
    nmi_ack = 1; instr_done = 1; e.f1 = 0; tick("nmi_holds_count");
    instr_done = 1; e.p = 0; tick("count_after_nmi");
    di = 1; e.f2 = 0; tick("di");
    retn = 1; tick("retn_zero");
    im_wr = 1; im_in = 2'd3; e.im = 2'd2; tick("im3_to_2");
    im_wr = 1; im_in = 2'd1; e.im = 2'd1; tick("im1");
    im_wr = 1; im_in = 2'd0; ei = 1; r_wr = 1; r_in = 8'h42; i_wr = 1; i_in = 8'h99;
    e.im = 2'd0; e.f1 = 1; e.f2 = 1; e.p = 1; e.r = 8'h42; e.i = 8'h99; tick("all_together");
    reset = 0; m1_inc = 1; instr_done = 1; i_wr = 1; i_in = 8'h55;
    e = '{i: 8'h00, r: 8'h00, f1: 0, f2: 0, p: 0, en: 0, im: 2'd0, tag: ""}; tick("reset_pending");
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
